// File: rtl/simon_input_conditioner.sv
// Conditions the Simon board inputs. It synchronizes the raw button and switches, debounces them,
// and turns each accepted button press into a single pattern-clock strobe.
module simon_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [3:0] pattern_raw,
    input  logic       level_raw,
    output logic       pclk,
    output logic [3:0] pattern,
    output logic       level,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } btn_state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizers, bit 0 = button, [4:1] = pattern, [5] = level
    // ------------------------------------------------------------------
    logic [5:0] sync1_q, sync1_d;
    logic [5:0] sync2_q, sync2_d;
    logic [1:0] sync_vld_q, sync_vld_d;

    logic       btn_s;
    logic [4:0] sw_s;

    always_comb begin
        sync1_d    = {level_raw, pattern_raw, btn_raw};
        sync2_d    = sync1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_vld_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync_vld_q <= sync_vld_d;
        end
    end

    assign btn_s = sync2_q[0];
    assign sw_s  = sync2_q[5:1];

    // ------------------------------------------------------------------
    // Button FSM
    // ------------------------------------------------------------------
    btn_state_e    state_q, state_d;
    logic [CW-1:0] bcnt_q, bcnt_d, bcnt_inc;
    logic          armed_q, armed_d;
    logic          pclk_q, pclk_d;
    logic          busy_q, busy_d;

    assign bcnt_inc = (bcnt_q == CNT_MAX) ? bcnt_q : bcnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        armed_d = armed_q;
        pclk_d  = 1'b0;

        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                // Only a genuine sample (not the reset value of the synchronizer) arms the FSM,
                // so a button held through reset must be released before it counts.
                if (!btn_s && sync_vld_q[1]) begin
                    armed_d = 1'b1;
                end
                if (btn_s && armed_q) begin
                    state_d = PRESS_CNT;
                    bcnt_d  = CW'(1);
                end
            end
            PRESS_CNT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end else if (bcnt_inc == CNT_MAX) begin
                    state_d = HELD;
                    bcnt_d  = '0;
                    pclk_d  = 1'b1;
                end else begin
                    bcnt_d = bcnt_inc;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = REL_CNT;
                    bcnt_d  = CW'(1);
                end else begin
                    bcnt_d = '0;
                end
            end
            REL_CNT: begin
                if (btn_s) begin
                    state_d = HELD;
                    bcnt_d  = '0;
                end else if (bcnt_inc == CNT_MAX) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end else begin
                    bcnt_d = bcnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            armed_q <= 1'b0;
            pclk_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            armed_q <= armed_d;
            pclk_q  <= pclk_d;
            busy_q  <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Switch debounce with freeze while a press is in progress
    // ------------------------------------------------------------------
    logic [4:0]    cand_q, cand_d;
    logic [CW-1:0] scnt_q, scnt_d, scnt_inc;
    logic [3:0]    pattern_q, pattern_d;
    logic          level_q, level_d;

    assign scnt_inc = (scnt_q == CNT_MAX) ? scnt_q : scnt_q + CW'(1);

    always_comb begin
        cand_d    = cand_q;
        scnt_d    = scnt_q;
        pattern_d = pattern_q;
        level_d   = level_q;

        if (busy_q) begin
            // Keep tracking the switches but hold the count at zero, so a full
            // stability window is required once the press has finished.
            cand_d = sw_s;
            scnt_d = '0;
        end else if (sw_s != cand_q) begin
            // The reloading edge is itself the first stable sample of the new value.
            cand_d = sw_s;
            scnt_d = CW'(1);
        end else begin
            scnt_d = scnt_inc;
            if (scnt_inc == CNT_MAX) begin
                {level_d, pattern_d} = cand_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q    <= '0;
            scnt_q    <= '0;
            pattern_q <= '0;
            level_q   <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            scnt_q    <= scnt_d;
            pattern_q <= pattern_d;
            level_q   <= level_d;
        end
    end

    assign pclk    = pclk_q;
    assign busy    = busy_q;
    assign pattern = pattern_q;
    assign level   = level_q;

endmodule

// File: tb/tb_simon_input_conditioner.sv
// Directed bench for simon_input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs are driven on the falling edge and outputs are checked on the falling edge.
module tb_simon_input_conditioner;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic [3:0] pattern_raw;
    logic       level_raw;
    logic       pclk;
    logic [3:0] pattern;
    logic       level;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int base;

    simon_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .pattern_raw (pattern_raw),
        .level_raw   (level_raw),
        .pclk        (pclk),
        .pattern     (pattern),
        .level       (level),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pclk === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst         = 1'b0;
        btn_raw     = 1'b0;
        pattern_raw = 4'b1010;
        level_raw   = 1'b1;
        tick(3);

        // Reset state, with switches already set
        chk("rst_pclk", pclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pattern", pattern, 4'h0);
        chk("rst_level", level, 0);

        // Release reset; the switch change first sampled at edge 1 lands after edge 6
        rst = 1'b1;
        base = pulse_cnt;
        tick(5);
        chk("sw_lat_e5", pattern, 4'h0);
        tick(1);
        chk("sw_lat_e6_pat", pattern, 4'b1010);
        chk("sw_lat_e6_lvl", level, 1);
        tick(4);
        chk("no_strobe_after_rst", pulse_cnt - base, 0);

        // Clean press
        base = pulse_cnt;
        btn_raw = 1'b1;
        tick(2);
        chk("press_busy_e2", busy, 0);
        tick(1);
        chk("press_busy_e3", busy, 1);
        tick(2);
        chk("press_pclk_e5", pclk, 0);
        tick(1);
        chk("press_pclk_e6", pclk, 1);
        chk("press_pattern_strobe", pattern, 4'b1010);
        tick(1);
        chk("press_pclk_e7", pclk, 0);
        tick(13);
        btn_raw = 1'b0;
        tick(5);
        chk("release_busy_e5", busy, 1);
        tick(1);
        chk("release_busy_e6", busy, 0);
        tick(4);
        chk("press_one_pulse", pulse_cnt - base, 1);

        // Bounce: 1,1,0,1,1,0 then 0
        base = pulse_cnt;
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b1; tick(1);
        btn_raw = 1'b0; tick(1);
        btn_raw = 1'b1; tick(1);
        chk("bounce_busy_e4", busy, 1);
        btn_raw = 1'b1; tick(1);
        chk("bounce_busy_e5", busy, 0);
        btn_raw = 1'b0; tick(1);
        tick(10);
        chk("bounce_no_pulse", pulse_cnt - base, 0);
        chk("bounce_busy_end", busy, 0);

        // Release glitch merges with the press
        base = pulse_cnt;
        btn_raw = 1'b1; tick(10);
        btn_raw = 1'b0; tick(2);
        btn_raw = 1'b1; tick(10);
        btn_raw = 1'b0; tick(10);
        tick(4);
        chk("glitch_one_pulse", pulse_cnt - base, 1);
        chk("glitch_busy_end", busy, 0);

        // Switch freeze while busy
        pattern_raw = 4'b0001;
        tick(8);
        chk("freeze_pre", pattern, 4'b0001);
        btn_raw = 1'b1;
        tick(8);
        pattern_raw = 4'b1000;
        tick(10);
        chk("freeze_held_pat", pattern, 4'b0001);
        chk("freeze_held_busy", busy, 1);
        btn_raw = 1'b0;
        tick(6);
        chk("freeze_idle_busy", busy, 0);
        chk("freeze_idle_pat", pattern, 4'b0001);
        tick(3);
        chk("freeze_e3_pat", pattern, 4'b0001);
        tick(1);
        chk("freeze_e4_pat", pattern, 4'b1000);

        // Reset mid-press, button held through reset
        base = pulse_cnt;
        btn_raw = 1'b1;
        tick(4);
        chk("midrst_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_pclk", pclk, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pattern", pattern, 4'h0);
        @(negedge clk);
        tick(2);
        rst = 1'b1;
        tick(15);
        chk("midrst_no_pulse", pulse_cnt - base, 0);
        chk("midrst_not_busy", busy, 0);
        btn_raw = 1'b0;
        tick(5);
        btn_raw = 1'b1;
        tick(6);
        chk("midrst_repress_pclk", pclk, 1);
        chk("midrst_repress_pat", pattern, 4'b1000);
        tick(4);
        btn_raw = 1'b0;
        tick(10);
        chk("midrst_one_pulse", pulse_cnt - base, 1);

        // Long hold
        base = pulse_cnt;
        btn_raw = 1'b1;
        tick(1000);
        chk("long_busy", busy, 1);
        chk("long_one_pulse", pulse_cnt - base, 1);
        btn_raw = 1'b0;
        tick(10);
        chk("long_busy_end", busy, 0);
        chk("long_total", pulse_cnt - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
